majority_accumulator: RTL and testbench
=======================================

Name: majority_accumulator

Overview:
- Bundling (majority) accumulator for one hypervector dimension in the HDC processor.
- Each beat it takes a per-core store mask and per-core result bits, and maps each core to +1, -1 or 0.
- Per-beat sums come from a pipelined adder tree and are added into a signed accumulator.
- At end of bundle it presents the majority bit, tie flag and raw total through a valid/ready handshake.

Parameters:
- CORENUM, 32: number of cores feeding the block; any value >= 2.
- W, 30: accumulator width (signed).
- TIE_VAL, 0: majority bit driven when total == 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  beat present.
- in_ready  out  1  block accepts beat.
- in_last  in  1  final beat of bundle; qualified by in_valid & in_ready.
- store  in  CORENUM  per-core store strobe.
- core_result  in  CORENUM  per-core result bit.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- bit_out  out  1  majority bit.
- tie  out  1  total == 0.
- total  out  W  signed accumulated total.
- overflow  out  1  sticky arithmetic-range flag for current bundle.

Behaviour:
- Reset (rst==0 at posedge): state IDLE, accumulator 0, tree pipeline flushed, overflow 0, out_valid 0. Other outputs are driven from the cleared accumulator: total 0, tie 1, bit_out TIE_VAL. Reset mid-bundle discards everything.
- Per-core map: store=0 -> 0; store=1 & result=1 -> +1; store=1 & result=0 -> -1.
- Pipeline on accepted beat: stage S0 registers the mapped values. Then L = max(1, clog2(CORENUM)) registered pairwise adder levels. Then one accumulate cycle. Beat-to-accumulator latency = L+2 cycles.
- Tree width: clog2(CORENUM+1)+1 bits signed. Odd operand counts pass through a level unchanged. The tree result is sign-extended to W.
- States:
  - IDLE: in_ready=1. An accepted beat clears the accumulator (its value enters from zero) and goes to ACCUM. If in_last is set on that beat, go to DRAIN instead.
  - ACCUM: in_ready=1. Accepted beat with in_last -> DRAIN.
  - DRAIN: in_ready=0. Count L+1 cycles until the last beat is accumulated, then -> DONE.
  - DONE: in_ready=0, out_valid=1. Outputs stay stable until out_valid & out_ready -> IDLE.
  - out_valid deasserts on the cycle after the handshake.
- Beats with in_valid=1 but in_ready=0 are not consumed; the sender holds them.
- Idle gaps (in_valid=0) inside ACCUM are allowed and contribute nothing.
- bit_out = 1 if total>0, 0 if total<0, TIE_VAL if 0.
- tie = (total==0).
- Outputs are combinational from the accumulator; they are only meaningful while out_valid=1.
- overflow clears at bundle start. It sets when an addition leaves the signed W range.
- Beat with all store=0 adds 0 but still counts as a beat; in_last on it still terminates the bundle.

Optional Feature:
- SATURATE_EN defined: the accumulator clamps at +(2^(W-1)-1) / -2^(W-1); overflow sets on clamp.
- SATURATE_EN undefined: two's-complement wrap; overflow sets on wrap. bit_out then reflects the wrapped value.

Decomposition:
- Package hdc_pkg:
  - sel_t (signed 2-bit), with constants SEL_POS=+1, SEL_NEG=-1, SEL_ZERO=0.
  - state_t enum {IDLE, ACCUM, DRAIN, DONE}.
  - Function for tree sum width.
- Sub-module adder_tree_pipe: parameters N and IW. Registered pairwise sum tree with a valid sideband. Latency clog2(N), minimum 1.

Test Plan (CORENUM=4, W=8, TIE_VAL=0 unless noted):
- Single beat, store=1111, result=1110, in_last -> after L+2 cycles DONE; total=+2, bit_out=1, tie=0, overflow=0.
- Three beats, store=1111, results 0000, 0001, 0011 (last) -> total=-6, bit_out=0.
- Two beats, result=1100 and 0011, all stored -> total=0, tie=1, bit_out=0. Rerun with TIE_VAL=1 -> bit_out=1.
- store=0101 with result=1111 -> only cores 0 and 2 count; total=+2. A beat with store=0000 adds 0.
- out_ready held 0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0. Release -> IDLE next cycle; the next bundle starts from 0.
- 40 beats of all +1 (W=8, max 127):
  - with SATURATE_EN -> total=127, overflow=1.
  - without -> total=160-256=-96, overflow=1.
  - Separately, assert rst=0 mid-bundle -> IDLE, out_valid=0, total=0.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared types and sizing helpers for the HDC bundling datapath.
package hdc_pkg;

  // Per-core contribution: +1, -1 or 0.
  typedef logic signed [1:0] sel_t;

  localparam sel_t SEL_POS  = 2'sb01;
  localparam sel_t SEL_NEG  = 2'sb11;
  localparam sel_t SEL_ZERO = 2'sb00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed width that holds any sum of n values in [-1, +1].
  function automatic int tree_w(input int n);
    return $clog2(n + 1) + 1;
  endfunction

  // Number of registered adder levels; a 2-input tree still gets one level.
  function automatic int tree_levels(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Operand count at level k of a pairwise tree over n leaves.
  function automatic int level_cnt(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Registered pairwise adder tree with a valid sideband.
// Each level adds neighbouring operands; an odd last operand passes through.
// Latency is tree_levels(N) cycles.
module adder_tree_pipe
  import hdc_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vld,
  input  logic [N*IW-1:0]      i_data,
  output logic                 o_vld,
  output logic signed [IW-1:0] o_sum
);

  localparam int L = tree_levels(N);

  logic [L-1:0] r_vld;

  genvar k;
  for (k = 1; k <= L; k++) begin : g_lvl
    localparam int CNT  = level_cnt(N, k);
    localparam int PCNT = level_cnt(N, k - 1);

    logic signed [IW-1:0] w_prev [PCNT];
    logic signed [IW-1:0] r_v    [CNT];

    if (k == 1) begin : g_from_in
      // Unpack the flat input bus into the first level's operands.
      always_comb begin
        for (int m = 0; m < PCNT; m++) begin
          w_prev[m] = signed'(i_data[m*IW +: IW]);
        end
      end
    end else begin : g_from_lvl
      assign w_prev = g_lvl[k-1].r_v;
    end

    // Pairwise add, or pass the unpaired last operand straight through.
    always_ff @(posedge clk) begin
      for (int j = 0; j < CNT; j++) begin
        if (2*j + 1 < PCNT) begin
          r_v[j] <= w_prev[2*j] + w_prev[(2*j + 1 < PCNT) ? 2*j + 1 : 2*j];
        end else begin
          r_v[j] <= w_prev[2*j];
        end
      end
    end
  end

  // Valid shift register tracking data through the levels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int m = 1; m < L; m++) begin
        r_vld[m] <= r_vld[m-1];
      end
    end
  end

  assign o_vld = r_vld[L-1];
  assign o_sum = g_lvl[L].r_v[0];

endmodule

// File: rtl/majority_accumulator.sv
// Bundling (majority) accumulator for one hypervector dimension.
// Build option: SATURATE_EN -- clamp the accumulator instead of wrapping.
//
// state | meaning
// IDLE  | waiting for first beat; accepting it clears accumulator/overflow
// ACCUM | accepting beats until one carries in_last
// DRAIN | no new beats; wait L+1 cycles for last beat to reach accumulator
// DONE  | result presented; hold until out_ready
module majority_accumulator
  import hdc_pkg::*;
#(
  parameter int CORENUM = 32,
  parameter int W       = 30,
  parameter bit TIE_VAL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [CORENUM-1:0]  store,
  input  logic [CORENUM-1:0]  core_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                bit_out,
  output logic                tie,
  output logic signed [W-1:0] total,
  output logic                overflow
);

  localparam int TW = tree_w(CORENUM);
  localparam int L  = tree_levels(CORENUM);
  localparam int CW = $clog2(L + 2);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(L);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_drain_cnt;
  logic                  w_accept;
  logic                  w_start;

  logic [CORENUM*TW-1:0] w_map;
  logic [CORENUM*TW-1:0] r_s0_data;
  logic                  r_s0_vld;

  logic                  w_tree_vld;
  logic signed [TW-1:0]  w_tree_sum;
  logic signed [W-1:0]   w_tree_ext;
  logic signed [W:0]     w_sum;
  logic                  w_range_err;
  logic signed [W-1:0]   w_acc_upd;
  logic signed [W-1:0]   r_acc;
  logic                  r_ovf;

  assign w_accept = in_valid & in_ready;
  assign w_start  = w_accept & (r_state == IDLE);

  // Map each core to +1 / -1 / 0, sign-extended to tree width.
  always_comb begin
    w_map = '0;
    for (int i = 0; i < CORENUM; i++) begin
      sel_t w_sel;
      w_sel = store[i] ? (core_result[i] ? SEL_POS : SEL_NEG) : SEL_ZERO;
      w_map[i*TW +: TW] = {{(TW-2){w_sel[1]}}, w_sel};
    end
  end

  // S0: register mapped values and the beat-valid flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s0_vld <= 1'b0;
    end else begin
      r_s0_vld <= w_accept;
    end
    r_s0_data <= w_map;
  end

  adder_tree_pipe #(
    .N  (CORENUM),
    .IW (TW)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_s0_vld),
    .i_data (r_s0_data),
    .o_vld  (w_tree_vld),
    .o_sum  (w_tree_sum)
  );

  // One extra bit on the sum exposes any excursion outside the W-bit range.
  assign w_tree_ext  = {{(W-TW){w_tree_sum[TW-1]}}, w_tree_sum};
  assign w_sum       = {r_acc[W-1], r_acc} + {w_tree_ext[W-1], w_tree_ext};
  assign w_range_err = w_sum[W] ^ w_sum[W-1];

`ifdef SATURATE_EN
  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

  // Clamp toward the true sign of the sum when it leaves the range.
  always_comb begin
    w_acc_upd = w_sum[W-1:0];
    if (w_range_err) begin
      w_acc_upd = w_sum[W] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  // Plain two's-complement wrap.
  always_comb begin
    w_acc_upd = w_sum[W-1:0];
  end
`endif

  // Accumulator and sticky overflow; both restart on the first beat of a bundle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_tree_vld) begin
      r_acc <= w_acc_upd;
      if (w_range_err) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = in_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Drain down-counter: loaded on DRAIN entry, DONE follows its terminal count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drain_cnt <= '0;
    end else if (w_next == DRAIN && r_state != DRAIN) begin
      r_drain_cnt <= DRAIN_LOAD;
    end else if (r_state == DRAIN && r_drain_cnt != '0) begin
      r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  assign total    = r_acc;
  assign tie      = (r_acc == '0);
  assign bit_out  = tie ? TIE_VAL : ~r_acc[W-1];
  assign overflow = r_ovf;

endmodule

// File: tb/tb_majority_accumulator.sv
// Directed bench for majority_accumulator (CORENUM=4, W=8).
// A second instance with TIE_VAL=1 shares the stimulus.
module tb_majority_accumulator;

  localparam int N  = 4;
  localparam int WD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [N-1:0] store = '0;
  logic [N-1:0] core_result = '0;

  logic in_ready, out_valid, bit_out, tie, overflow;
  logic signed [WD-1:0] total;
  logic t1_in_ready, t1_out_valid, t1_bit_out, t1_tie, t1_overflow;
  logic signed [WD-1:0] t1_total;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  majority_accumulator #(.CORENUM(N), .W(WD), .TIE_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .store(store), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .bit_out(bit_out),
    .tie(tie), .total(total), .overflow(overflow)
  );

  majority_accumulator #(.CORENUM(N), .W(WD), .TIE_VAL(1'b1)) dut_t1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t1_in_ready),
    .in_last(in_last), .store(store), .core_result(core_result),
    .out_valid(t1_out_valid), .out_ready(out_ready), .bit_out(t1_bit_out),
    .tie(t1_tie), .total(t1_total), .overflow(t1_overflow)
  );

  task automatic send_beat(input logic [N-1:0] s, input logic [N-1:0] r, input logic last);
    store = s; core_result = r; in_valid = 1'b1; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (total !== 8'sd0) begin errors++; $display("FAIL reset_total: got %0d want 0", total); end
    checks++; if (tie !== 1'b1) begin errors++; $display("FAIL reset_tie: got %0b want 1", tie); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %0b want 0", bit_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int n;
    send_beat(4'b1111, 4'b1110, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_drain_ready: got %0b want 0", in_ready); end
    wait_done(n);
    checks++; if (n != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", n); end
    checks++; if (total !== 8'sd2) begin errors++; $display("FAIL single_total: got %0d want 2", total); end
    checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL single_bit_out: got %0b want 1", bit_out); end
    checks++; if (tie !== 1'b0) begin errors++; $display("FAIL single_tie: got %0b want 0", tie); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %0b want 0", overflow); end
    handshake();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_out_valid_drop: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_three();
    int n;
    send_beat(4'b1111, 4'b0000, 1'b0);
    send_beat(4'b1111, 4'b0001, 1'b0);
    send_beat(4'b1111, 4'b0011, 1'b1);
    wait_done(n);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL three_done: got %0b want 1", out_valid); end
    checks++; if (total !== -8'sd6) begin errors++; $display("FAIL three_total: got %0d want -6", total); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL three_bit_out: got %0b want 0", bit_out); end
    handshake();
  endtask

  task automatic test_tie();
    int n;
    send_beat(4'b1111, 4'b1100, 1'b0);
    send_beat(4'b1111, 4'b0011, 1'b1);
    wait_done(n);
    checks++; if (total !== 8'sd0) begin errors++; $display("FAIL tie_total: got %0d want 0", total); end
    checks++; if (tie !== 1'b1) begin errors++; $display("FAIL tie_flag: got %0b want 1", tie); end
    checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL tie_bit_out_tv0: got %0b want 0", bit_out); end
    checks++; if (t1_bit_out !== 1'b1) begin errors++; $display("FAIL tie_bit_out_tv1: got %0b want 1", t1_bit_out); end
    checks++; if (t1_tie !== 1'b1) begin errors++; $display("FAIL tie_flag_tv1: got %0b want 1", t1_tie); end
    checks++; if (t1_total !== 8'sd0) begin errors++; $display("FAIL tie_total_tv1: got %0d want 0", t1_total); end
    checks++; if (t1_out_valid !== 1'b1) begin errors++; $display("FAIL tie_out_valid_tv1: got %0b want 1", t1_out_valid); end
    checks++; if (t1_in_ready !== 1'b0) begin errors++; $display("FAIL tie_in_ready_tv1: got %0b want 0", t1_in_ready); end
    checks++; if (t1_overflow !== 1'b0) begin errors++; $display("FAIL tie_overflow_tv1: got %0b want 0", t1_overflow); end
    handshake();
  endtask

  task automatic test_store_mask();
    int n;
    send_beat(4'b0101, 4'b1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mask_gap_ready: got %0b want 1", in_ready); end
    send_beat(4'b0000, 4'b1111, 1'b1);
    wait_done(n);
    checks++; if (total !== 8'sd2) begin errors++; $display("FAIL mask_total: got %0d want 2", total); end
    checks++; if (bit_out !== 1'b1) begin errors++; $display("FAIL mask_bit_out: got %0b want 1", bit_out); end
    handshake();
    send_beat(4'b0000, 4'b0000, 1'b1);
    wait_done(n);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_done: got %0b want 1", out_valid); end
    checks++; if (total !== 8'sd0) begin errors++; $display("FAIL empty_total: got %0d want 0", total); end
    handshake();
  endtask

  task automatic test_backpressure();
    int n;
    send_beat(4'b1111, 4'b1011, 1'b1);
    wait_done(n);
    store = 4'b1111; core_result = 4'b0001; in_valid = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c=%0d: got %0b want 1", c, out_valid); end
      checks++; if (total !== 8'sd2) begin errors++; $display("FAIL bp_total c=%0d: got %0d want 2", c, total); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d: got %0b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(n);
    checks++; if (n != 3) begin errors++; $display("FAIL bp_next_latency: got %0d want 3", n); end
    checks++; if (total !== -8'sd2) begin errors++; $display("FAIL bp_next_total: got %0d want -2", total); end
    handshake();
  endtask

  task automatic test_overflow();
    int n;
    logic signed [WD-1:0] exp_total;
    logic exp_bit;
`ifdef SATURATE_EN
    exp_total = 8'sd127; exp_bit = 1'b1;
`else
    exp_total = -8'sd96; exp_bit = 1'b0;
`endif
    for (int i = 0; i < 40; i++) begin
      send_beat(4'b1111, 4'b1111, (i == 39));
    end
    wait_done(n);
    checks++; if (total !== exp_total) begin errors++; $display("FAIL ovf_total: got %0d want %0d", total, exp_total); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    checks++; if (bit_out !== exp_bit) begin errors++; $display("FAIL ovf_bit_out: got %0b want %0b", bit_out, exp_bit); end
    handshake();
    send_beat(4'b1111, 4'b1111, 1'b1);
    wait_done(n);
    checks++; if (total !== 8'sd4) begin errors++; $display("FAIL ovf_next_total: got %0d want 4", total); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %0b want 0", overflow); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int n;
    send_beat(4'b1111, 4'b1111, 1'b0);
    send_beat(4'b1111, 4'b1111, 1'b0);
    send_beat(4'b1111, 4'b1111, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %0b want 0", out_valid); end
    checks++; if (total !== 8'sd0) begin errors++; $display("FAIL rmid_total: got %0d want 0", total); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %0b want 1", in_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (total !== 8'sd0) begin errors++; $display("FAIL rmid_flushed: got %0d want 0", total); end
    send_beat(4'b1111, 4'b1110, 1'b1);
    wait_done(n);
    checks++; if (total !== 8'sd2) begin errors++; $display("FAIL rmid_after_total: got %0d want 2", total); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_tie();
    test_store_mask();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
